// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and carry-in in, handshake and result out.
// The master side issues start with operands; the slave side (the adder) returns busy/done/sum/cout.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around one full-adder cell; done pulses WIDTH+1 edges after start is taken.
// No backpressure: start is only sampled in IDLE, so back-to-back issue is one per WIDTH+2 cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             is_busy;
  logic             is_done;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_carry;

  // The single full-adder cell, fed by the operand LSBs and the carry flop.
  assign fa_sum   = sa[0] ^ sb[0] ^ c;
  assign fa_carry = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));
  assign acc_nxt  = (acc >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    is_busy   = 1'b0;
    is_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        is_busy = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        is_done   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            c   <= bus.cin;
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          acc <= acc_nxt;
          c   <= fa_carry;
          cnt <= cnt + CW'(1);
          // Publish on the last bit so the result appears together with done.
          if (cnt == LAST) begin
            sum_q  <= acc_nxt;
            cout_q <= fa_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = is_busy;
  assign bus.done = is_done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
